// File: rtl/instruction_fetch_unit.sv
// Fetch unit: one outstanding memory read feeding a 2-entry buffer.
// Optional unconditional-B predecode enabled by `IFU_PREDECODE_B_EN.
module instruction_fetch_unit #(
  parameter int RD_WAIT = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startPC,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        if_pred_taken,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    FULL
  } state_t;

  localparam logic [3:0] WAITN = 4'(RD_WAIT);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [63:0] fetch_pc;
  logic [1:0]  count;
  logic [1:0]  post_count;
  logic        capture;
  logic        deq;
  logic        wr_head;
  logic        cap_pt;
  logic [63:0] cap_next_pc;

  logic [31:0] h_instr, t_instr;
  logic [63:0] h_pc, t_pc;
  logic        h_pt, t_pt;

  logic        unused_bits;
  assign unused_bits = ^{startPC[1:0], redirect_pc[1:0]};

  assign capture = (state == WAIT) && (cnt == 4'd1) && !redirect_valid;
  assign deq     = (count != 2'd0) && id_ready && !redirect_valid;
  assign post_count = count + {1'b0, capture} - {1'b0, deq};
  assign wr_head = (count == 2'd0) || ((count == 2'd1) && deq);

`ifdef IFU_PREDECODE_B_EN
  logic [63:0] b_off;
  assign cap_pt = (imem_data[31:26] == 6'b000101);
  assign b_off  = {{36{imem_data[25]}}, imem_data[25:0], 2'b00};
  assign cap_next_pc = cap_pt ? (fetch_pc + b_off)
                              : (fetch_pc + 64'd4);
`else
  assign cap_pt = 1'b0;
  assign cap_next_pc = fetch_pc + 64'd4;
`endif

  assign imem_addr     = fetch_pc;
  assign if_valid      = (count != 2'd0);
  assign if_instr      = h_instr;
  assign if_pc         = h_pc;
  assign if_pred_taken = h_pt;

  // State register.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) state <= ISSUE;
    else         state <= state_nx;
  end

  // Next state: issue, wait out the read, stall when buffer full.
  always_comb begin
    state_nx = state;
    unique case (state)
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (cnt == 4'd1)
          state_nx = (post_count < 2'd2) ? ISSUE : FULL;
      end
      FULL: begin
        if (deq) state_nx = ISSUE;
      end
      default: state_nx = ISSUE;
    endcase
    if (redirect_valid) state_nx = ISSUE;
  end

  // Wait counter and fetch address.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      cnt      <= 4'd0;
      fetch_pc <= {startPC[63:2], 2'b00};
    end else if (redirect_valid) begin
      cnt      <= 4'd0;
      fetch_pc <= {redirect_pc[63:2], 2'b00};
    end else begin
      if (state == ISSUE)
        cnt <= WAITN;
      else if ((state == WAIT) && (cnt != 4'd0))
        cnt <= cnt - 4'd1;
      if (capture) fetch_pc <= cap_next_pc;
    end
  end

  // Two-entry buffer; head shifts forward on dequeue.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      count   <= 2'd0;
      h_instr <= 32'd0;
      h_pc    <= 64'd0;
      h_pt    <= 1'b0;
      t_instr <= 32'd0;
      t_pc    <= 64'd0;
      t_pt    <= 1'b0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      count <= post_count;
      if (deq) begin
        h_instr <= t_instr;
        h_pc    <= t_pc;
        h_pt    <= t_pt;
      end
      if (capture) begin
        if (wr_head) begin
          h_instr <= imem_data;
          h_pc    <= fetch_pc;
          h_pt    <= cap_pt;
        end else begin
          t_instr <= imem_data;
          t_pc    <= fetch_pc;
          t_pt    <= cap_pt;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: stream model plus directed timing checks.
// Honours `IFU_PREDECODE_B_EN when the design is built with it.
module tb_instruction_fetch_unit;

  logic        CLK;
  logic        resetl;
  logic [63:0] startPC;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_pred_taken;
  logic        id_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  logic [31:0] mem [64];
  int errors = 0;
  int checks = 0;
  int ndeliv = 0;

  assign imem_data = mem[imem_addr[7:2]];

  instruction_fetch_unit #(.RD_WAIT(2)) dut (
    .CLK(CLK),
    .resetl(resetl),
    .startPC(startPC),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_pred_taken(if_pred_taken),
    .id_ready(id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic void chk(input string nm,
                              input logic [63:0] got,
                              input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  // Instruction-stream model: the program order of fetched words.
  function automatic logic [63:0] next_pc(input logic [63:0] pc,
                                          input logic [31:0] w);
`ifdef IFU_PREDECODE_B_EN
    if (w[31:26] == 6'b000101)
      return pc + {{36{w[25]}}, w[25:0], 2'b00};
`endif
    return pc + 64'd4;
  endfunction

  function automatic logic is_pred(input logic [31:0] w);
`ifdef IFU_PREDECODE_B_EN
    return w[31:26] == 6'b000101;
`else
    return (w == 32'd0) && (w != 32'd0);
`endif
  endfunction

  // Compare process: the head must always be the next word in program order.
  initial begin
    logic [63:0] mpc;
    logic [31:0] w;
    mpc = 64'd0;
    forever begin
      @(negedge CLK);
      #3;
      if (!resetl) begin
        mpc = {startPC[63:2], 2'b00};
        chk("rst_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_pc", if_pc, 64'd0);
        chk("rst_instr", {32'd0, if_instr}, 64'd0);
      end else begin
        if (if_valid) begin
          w = mem[mpc[7:2]];
          chk("head_pc", if_pc, mpc);
          chk("head_instr", {32'd0, if_instr}, {32'd0, w});
          chk("head_pred", {63'd0, if_pred_taken},
              {63'd0, is_pred(w)});
        end
        if (redirect_valid) begin
          mpc = {redirect_pc[63:2], 2'b00};
        end else if (if_valid && id_ready) begin
          mpc = next_pc(mpc, mem[mpc[7:2]]);
          ndeliv++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] spc, input logic rdy);
    @(negedge CLK);
    #1;
    resetl = 1'b0;
    startPC = spc;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    @(negedge CLK);
    #1;
    resetl = 1'b1;
    id_ready = rdy;
  endtask

  initial begin
    int n0;
    logic [63:0] exp_nx;
    logic        exp_pt;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + 32'(i);
    resetl = 1'b1;
    startPC = 64'd0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;

    // Reset state
    #1 resetl = 1'b0;
    #1;
    chk("t1_valid", {63'd0, if_valid}, 64'd0);
    chk("t1_pc", if_pc, 64'd0);
    chk("t1_instr", {32'd0, if_instr}, 64'd0);
    chk("t1_pred", {63'd0, if_pred_taken}, 64'd0);
    chk("t1_addr", imem_addr, 64'd0);

    // Streaming: one word every three cycles
    do_reset(64'd0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) cyc(1);
      chk("t2_valid", {63'd0, if_valid},
          {63'd0, (k > 0) && (k % 3 == 0)});
      chk("t2_addr", imem_addr, 64'(4 * (k / 3)));
      if ((k > 0) && (k % 3 == 0))
        chk("t2_pc", if_pc, 64'(4 * (k / 3 - 1)));
    end

    // Backpressure: buffer fills, then drains in order
    do_reset(64'd0, 1'b0);
    n0 = ndeliv;
    cyc(6);
    chk("t3_full_valid", {63'd0, if_valid}, 64'd1);
    chk("t3_full_pc", if_pc, 64'h0);
    chk("t3_full_addr", imem_addr, 64'h8);
    cyc(2);
    chk("t3_hold_addr", imem_addr, 64'h8);
    chk("t3_hold_pc", if_pc, 64'h0);
    cyc(1);
    id_ready = 1'b1;
    cyc(1);
    chk("t3_second_pc", if_pc, 64'h4);
    chk("t3_second_addr", imem_addr, 64'h8);
    cyc(3);
    chk("t3_third_valid", {63'd0, if_valid}, 64'd1);
    chk("t3_third_pc", if_pc, 64'h8);
    cyc(1);
    chk("t3_count", 64'(ndeliv - n0), 64'd3);
    id_ready = 1'b0;

    // Redirect during a wait with 0x10 buffered
    do_reset(64'h10, 1'b0);
    cyc(4);
    chk("t4_pre_pc", if_pc, 64'h10);
    redirect_valid = 1'b1;
    redirect_pc = 64'h1C;
    cyc(1);
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    chk("t4_flush_valid", {63'd0, if_valid}, 64'd0);
    chk("t4_addr", imem_addr, 64'h1C);
    cyc(3);
    chk("t4_valid", {63'd0, if_valid}, 64'd1);
    chk("t4_pc", if_pc, 64'h1C);
    chk("t4_instr", {32'd0, if_instr}, {32'd0, mem[7]});

    // Redirect coinciding with dequeue and capture
    do_reset(64'd0, 1'b0);
    cyc(5);
    chk("t5_pre_pc", if_pc, 64'h0);
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h3;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t5_valid", {63'd0, if_valid}, 64'd0);
    chk("t5_addr", imem_addr, 64'h0);
    cyc(3);
    chk("t5_pc", if_pc, 64'h0);
    chk("t5_after_valid", {63'd0, if_valid}, 64'd1);

    // Unconditional B word at 0x28
    mem[10] = 32'h17FF_FFFD;
`ifdef IFU_PREDECODE_B_EN
    exp_nx = 64'h1C;
    exp_pt = 1'b1;
`else
    exp_nx = 64'h2C;
    exp_pt = 1'b0;
`endif
    do_reset(64'h28, 1'b1);
    cyc(3);
    chk("t6_pc", if_pc, 64'h28);
    chk("t6_instr", {32'd0, if_instr}, 64'h17FF_FFFD);
    chk("t6_pred", {63'd0, if_pred_taken}, {63'd0, exp_pt});
    chk("t6_addr", imem_addr, exp_nx);
    cyc(3);
    chk("t6_next_pc", if_pc, exp_nx);

    // Reset pulse mid-wait
    cyc(1);
    resetl = 1'b0;
    startPC = 64'h34;
    #1;
    chk("t7_valid", {63'd0, if_valid}, 64'd0);
    chk("t7_pc", if_pc, 64'd0);
    chk("t7_instr", {32'd0, if_instr}, 64'd0);
    chk("t7_pred", {63'd0, if_pred_taken}, 64'd0);
    cyc(1);
    chk("t7_low_valid", {63'd0, if_valid}, 64'd0);
    resetl = 1'b1;
    chk("t7_addr", imem_addr, 64'h34);
    cyc(3);
    chk("t7_first_pc", if_pc, 64'h34);
    chk("t7_first_valid", {63'd0, if_valid}, 64'd1);

    // Address wrap at the top of the space
    do_reset(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    chk("t8_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(3);
    chk("t8_pc0", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t8_addr1", imem_addr, 64'h0);
    cyc(3);
    chk("t8_pc1", if_pc, 64'h0);

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RD_WAIT, default 2, meaning cycles from address launch to instruction capture (legal 1..15).
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetl  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port startPC  input  64  fetch address loaded at reset.
REQ-005 SHALL have port imem_addr  output  64  address to instruction memory.
REQ-006 SHALL have port imem_data  input  32  instruction word returned by memory.
REQ-007 SHALL have port if_valid  output  1  buffer head holds a valid instruction.
REQ-008 SHALL have port if_instr  output  32  instruction at buffer head.
REQ-009 SHALL have port if_pc  output  64  address of if_instr.
REQ-010 SHALL have port if_pred_taken  output  1  head instruction was predecoded as an unconditional B.
REQ-011 SHALL have port id_ready  input  1  decode accepts head this cycle.
REQ-012 SHALL have port redirect_valid  input  1  branch resolved; restart fetch.
REQ-013 SHALL have port redirect_pc  input  64  restart address.

Function
REQ-014 SHALL hold a 2-entry FIFO of {instr, pc, pred_taken}; head drives if_instr/if_pc/if_pred_taken; if_valid = count != 0.
REQ-015 SHALL dequeue the head on a rising edge where if_valid and id_ready are both 1.
REQ-016 SHALL run FSM states ISSUE, WAIT and FULL.
REQ-017 In ISSUE: imem_addr = fetch_pc; wait counter loaded to RD_WAIT; next state WAIT.
REQ-018 In WAIT: imem_addr held stable; counter decrements each cycle; at the edge where counter reaches 1, imem_data is enqueued with pc = fetch_pc and fetch_pc advances by 4.
REQ-019 After a capture: next state ISSUE if post-edge count < 2, else FULL.
REQ-020 In FULL: no capture; imem_addr = fetch_pc; state moves to ISSUE on the edge where a dequeue occurs.
REQ-021 SHALL have at most one fetch in flight, so a capture never overflows the FIFO; a simultaneous capture and dequeue leaves count unchanged.
REQ-022 Throughput with id_ready=1 SHALL be one instruction per RD_WAIT+1 cycles.
REQ-023 redirect_valid SHALL have priority over capture and dequeue: FIFO flushed (count=0); in-flight word discarded; fetch_pc = {redirect_pc[63:2], 2'b00}; next state ISSUE.
REQ-024 fetch_pc arithmetic SHALL be 64-bit modulo 2^64; increment from 0xFFFF_FFFF_FFFF_FFFC wraps to 0.

Reset
REQ-025 When resetl=0, SHALL immediately set: FIFO count 0, if_valid 0, if_instr 0, if_pc 0, if_pred_taken 0, fetch_pc = {startPC[63:2],2'b00}, state ISSUE, counter 0.
REQ-026 Reset asserted mid-WAIT SHALL abandon the fetch; after release the first issued address is startPC.

Configuration
REQ-027 With IFU_PREDECODE_B_EN defined, a captured word with bits[31:26]=6'b000101 SHALL be enqueued with pred_taken=1 and fetch_pc set to capture pc + (sign-extended imm26 << 2) instead of pc+4.
REQ-028 Without IFU_PREDECODE_B_EN, pred_taken SHALL always be 0 and fetch is strictly sequential apart from redirects.

Verification
REQ-029 startPC=0, RD_WAIT=2, id_ready=1, memory with words at 0x0..0x2C -> imem_addr 0x0, 0x4, 0x8...; if_valid pulses once per 3 cycles with if_pc 0x0, 0x4, 0x8 and matching words.
REQ-030 id_ready=0 from reset -> FIFO fills with pc 0x0, 0x4; state FULL, imem_addr=0x8, no further capture; raise id_ready -> delivered order 0x0, 0x4, 0x8 with none lost or duplicated.
REQ-031 redirect_valid=1, redirect_pc=0x1C during WAIT with FIFO holding 0x10 -> next cycle if_valid=0, imem_addr=0x1C; next delivered if_pc=0x1C; in-flight word never appears.
REQ-032 redirect_pc=0x3 in the same cycle as dequeue and capture -> FIFO empty, next issued address 0x0.
REQ-033 Macro on: word 0x17FFFFFD captured at 0x28 -> if_pred_taken=1, next delivered if_pc=0x1C; macro off -> if_pred_taken=0, next if_pc=0x2C.
REQ-034 resetl pulsed low during WAIT with startPC=0x34 -> outputs zero while low; after release, first imem_addr=0x34 and first if_pc=0x34.
